cordic_pipe: RTL
================

Name: cordic_pipe

Overview:
- Parametrised, fully pipelined CORDIC engine; next generation of the single-mode `cordic` core.
- Accepts one sample per clock. Each sample carries its own rotation/vector mode bit.
- Uses a ready/valid handshake with whole-pipeline backpressure, a quadrant pre-rotation stage and saturating outputs.
- Sits between sample sources (file-driven benches, mixers) and downstream magnitude/phase or NCO consumers.

Parameters:
- WIDTH, 16: signed width of x/y inputs and outputs.
- ANGLE_W, 16: signed width of z; binary angle, full scale ±pi (2^(ANGLE_W-1) = pi).
- STAGES, 14: number of micro-rotation stages; legal range 4..min(WIDTH,ANGLE_W)-1.
- GUARD, 2: extra internal MSBs on x/y datapath.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  input sample valid.
- in_ready  out  1  engine can accept a sample this cycle.
- in_mode  in  1  0 = rotation, 1 = vectoring.
- x_in  in  WIDTH  signed x.
- y_in  in  WIDTH  signed y.
- z_in  in  ANGLE_W  signed angle.
- out_valid  out  1  output sample valid.
- out_ready  in  1  downstream accepts output.
- out_mode  out  1  mode of the sample at the output.
- x_out  out  WIDTH  signed x result, saturated.
- y_out  out  WIDTH  signed y result, saturated.
- z_out  out  ANGLE_W  signed angle result, wraps modulo 2pi.

Behaviour:
- Reset: rst high at a clock edge clears every stage valid bit and every data register. out_valid=0, x_out=y_out=z_out=0, out_mode=0. Samples in flight are discarded. in_ready=1 the cycle after reset.
- Advance: adv = out_ready | ~out_valid. When adv=1 every stage loads from its predecessor (valid and data); when adv=0 all stages hold. in_ready = adv, combinational. Accept happens when in_valid & in_ready. Bubbles are not squeezed out.
- Latency: STAGES+2 advancing cycles (1 pre-rotation + STAGES iterations + 1 output/saturation register). With out_ready held at 1, out_valid rises exactly STAGES+2 cycles after an accept. Throughput is 1 sample/cycle.
- Internal x/y width is WIDTH+GUARD, sign-extended on entry, so negation of -2^(WIDTH-1) cannot overflow. z keeps ANGLE_W bits and wraps in two's complement.
- Pre-rotation, Q = 2^(ANGLE_W-2) (90°):
  - Rotation mode, z top two bits = 01: x'=-y, y'=x, z'=z-Q.
  - Rotation mode, z top two bits = 10: x'=y, y'=-x, z'=z+Q.
  - Vector mode, x<0 and y>=0: x'=y, y'=-x, z'=z+Q.
  - Vector mode, x<0 and y<0: x'=-y, y'=x, z'=z-Q.
  - Otherwise the sample passes unchanged.
- Stage i (i=0..STAGES-1):
  - Direction: d=+1 if (mode=0 ? z>=0 : y<0), else d=-1.
  - x'=x-d*(y>>>i); y'=y+d*(x>>>i); z'=z-d*A[i].
  - A[i] = round(atan(2^-i)/pi * 2^(ANGLE_W-1)), taken from a constant 32-entry 32-bit table right-shifted with rounding to ANGLE_W.
  - Mode propagates with the data.
- Gain is not compensated: magnitude scales by K≈1.6468.
- Output register: x/y saturate to [-2^(WIDTH-1), 2^(WIDTH-1)-1]; z is passed through.
- Simultaneous accept and emit in the same cycle is legal. Mode may change every sample.
- in_valid or data changing while in_ready=0 has no effect.

Test Plan:
- Rotation, x=10000, y=0, z=0, out_ready=1: after 16 cycles out_valid=1, x_out=16468±4, y_out=0±4, z_out=0±4.
- Rotation, x=10000, y=0, z=16384 (90°): y_out=16468±4, x_out=0±4. With z=-32768 (180°): x_out=-16468±4, y_out=0±4.
- Vector, x=0, y=10000: x_out=16468±4, y_out=0±4, z_out=16384±4. With x=-10000, y=0: z_out within 4 LSB of ±32768 (wrap accepted).
- Saturation, vector, x=y=32767: x_out=32767 (true value ≈76313), z_out=8192±4.
- Backpressure and interleaving:
  - Stream 40 samples with alternating modes. Drop out_ready for 5 random bursts.
  - Require no loss or duplication, in-order results matching the bit-accurate model, and in_ready=0 exactly while out_valid=1 and out_ready=0.
- Reset mid-stream: assert rst for one cycle with 10 samples in flight. Next cycle out_valid=0 and all outputs 0. First post-reset sample emerges after 16 cycles with correct values.

Source files
------------

// File: rtl/cordic_pipe.sv
// Fully pipelined CORDIC engine: quadrant pre-rotation, STAGES micro-rotations and a
// saturating output register. Each sample carries its own rotation/vectoring mode bit.
module cordic_pipe #(
  parameter int WIDTH   = 16,
  parameter int ANGLE_W = 16,
  parameter int STAGES  = 14,
  parameter int GUARD   = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic                      in_mode,
  input  logic signed [WIDTH-1:0]   x_in,
  input  logic signed [WIDTH-1:0]   y_in,
  input  logic signed [ANGLE_W-1:0] z_in,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic                      out_mode,
  output logic signed [WIDTH-1:0]   x_out,
  output logic signed [WIDTH-1:0]   y_out,
  output logic signed [ANGLE_W-1:0] z_out
);

  localparam int IW = WIDTH + GUARD;
  localparam int SH = 32 - ANGLE_W;
  localparam logic [ANGLE_W-1:0] QUARTER = {2'b01, {(ANGLE_W-2){1'b0}}};
  localparam logic signed [IW-1:0] MAXV = {{(GUARD+1){1'b0}}, {(WIDTH-1){1'b1}}};
  localparam logic signed [IW-1:0] MINV = {{(GUARD+1){1'b1}}, {(WIDTH-1){1'b0}}};

  // round(atan(2^-i) / pi * 2^31)
  localparam logic [31:0] ATAN_TAB [32] = '{
    32'h20000000, 32'h12E4051E, 32'h09FB385B, 32'h051111D4,
    32'h028B0D43, 32'h0145D7E1, 32'h00A2F61E, 32'h00517C55,
    32'h0028BE53, 32'h00145F2F, 32'h000A2F98, 32'h000517CC,
    32'h00028BE6, 32'h000145F3, 32'h0000A2FA, 32'h0000517D,
    32'h000028BE, 32'h0000145F, 32'h00000A30, 32'h00000518,
    32'h0000028C, 32'h00000146, 32'h000000A3, 32'h00000051,
    32'h00000029, 32'h00000014, 32'h0000000A, 32'h00000005,
    32'h00000003, 32'h00000001, 32'h00000001, 32'h00000000
  };

  function automatic logic [ANGLE_W-1:0] atan_ang(input int i);
    logic [32:0] t;
    t = {1'b0, ATAN_TAB[i[4:0]]};
    if (SH > 0) t = (t + (33'd1 << (SH - 1))) >> SH;
    return t[ANGLE_W-1:0];
  endfunction

  function automatic logic [WIDTH-1:0] sat(input logic signed [IW-1:0] v);
    if (v > MAXV) return MAXV[WIDTH-1:0];
    if (v < MINV) return MINV[WIDTH-1:0];
    return v[WIDTH-1:0];
  endfunction

  // Handshake: a sample transfers on a rising edge where valid & ready are both high.
  // The whole pipeline advances together; it stalls only when the output holds an
  // unaccepted sample, so in_ready is simply the advance enable.
  logic adv;
  assign adv      = out_ready | ~out_valid;
  assign in_ready = adv;

  logic signed [IW-1:0]  xe, ye, px, py;
  logic [ANGLE_W-1:0]    pz;
  assign xe = {{GUARD{x_in[WIDTH-1]}}, x_in};
  assign ye = {{GUARD{y_in[WIDTH-1]}}, y_in};

  // Fold the input into the +/-90 degree convergence range of the micro-rotations.
  always_comb begin
    px = xe;
    py = ye;
    pz = z_in;
    if (!in_mode) begin
      case (z_in[ANGLE_W-1 -: 2])
        2'b01:   begin px = -ye; py = xe;  pz = z_in - QUARTER; end
        2'b10:   begin px = ye;  py = -xe; pz = z_in + QUARTER; end
        default: ;
      endcase
    end else if (x_in[WIDTH-1]) begin
      if (!y_in[WIDTH-1]) begin
        px = ye;  py = -xe; pz = z_in + QUARTER;
      end else begin
        px = -ye; py = xe;  pz = z_in - QUARTER;
      end
    end
  end

  // Index 0 is the pre-rotation register; index k holds the result of iteration k-1.
  logic signed [IW-1:0] sx [0:STAGES];
  logic signed [IW-1:0] sy [0:STAGES];
  logic [ANGLE_W-1:0]   sz [0:STAGES];
  logic [STAGES:0]      sv, sm;

  logic signed [IW-1:0] nx [1:STAGES];
  logic signed [IW-1:0] ny [1:STAGES];
  logic [ANGLE_W-1:0]   nz [1:STAGES];

  always_comb begin
    for (int k = 0; k < STAGES; k++) begin
      if (sm[k] ? sy[k][IW-1] : ~sz[k][ANGLE_W-1]) begin
        nx[k+1] = sx[k] - (sy[k] >>> k);
        ny[k+1] = sy[k] + (sx[k] >>> k);
        nz[k+1] = sz[k] - atan_ang(k);
      end else begin
        nx[k+1] = sx[k] + (sy[k] >>> k);
        ny[k+1] = sy[k] - (sx[k] >>> k);
        nz[k+1] = sz[k] + atan_ang(k);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sv <= '0;
      sm <= '0;
      for (int k = 0; k <= STAGES; k++) begin
        sx[k] <= '0;
        sy[k] <= '0;
        sz[k] <= '0;
      end
      out_valid <= 1'b0;
      out_mode  <= 1'b0;
      x_out     <= '0;
      y_out     <= '0;
      z_out     <= '0;
    end else if (adv) begin
      sv    <= {sv[STAGES-1:0], in_valid};
      sm    <= {sm[STAGES-1:0], in_mode};
      sx[0] <= px;
      sy[0] <= py;
      sz[0] <= pz;
      for (int k = 1; k <= STAGES; k++) begin
        sx[k] <= nx[k];
        sy[k] <= ny[k];
        sz[k] <= nz[k];
      end
      out_valid <= sv[STAGES];
      out_mode  <= sm[STAGES];
      x_out     <= sat(sx[STAGES]);
      y_out     <= sat(sy[STAGES]);
      z_out     <= sz[STAGES];
    end
  end

endmodule
